// File: rtl/bcd_seg7_scanner_if.sv
// Digit inputs and display pins shared between the stopwatch BCD counter
// and the 3-digit multiplexed 7-segment scanner.
interface bcd_seg7_scanner_if;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] ms0;
    logic       hold;
    logic       blank;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] an;

    modport master (
        output s1, s0, ms0, hold, blank,
        input  seg, dp, an
    );

    modport slave (
        input  s1, s0, ms0, hold, blank,
        output seg, dp, an
    );
endinterface

// File: rtl/bcd_seg7_scanner.sv
// Snapshots s1/s0/ms0 and scans them onto a common-anode 3-digit display
// as "s1 s0 . ms0" with per-slot anti-ghost blanking and leading-zero blanking.
//
//  state | meaning
//  DIG0  | ms0 slot, an[0] driven
//  DIG1  | s0 slot,  an[1] driven, decimal point lit
//  DIG2  | s1 slot,  an[2] driven unless leading zero is suppressed
module bcd_seg7_scanner #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 4,
    parameter int LZB          = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_seg7_scanner_if.slave   bus
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          w_tc;
    logic [3:0]    r_s1;
    logic [3:0]    r_s0;
    logic [3:0]    r_ms0;
    logic [3:0]    w_digit;
    logic          w_show;
    logic [6:0]    r_seg;
    logic [6:0]    w_seg;
    logic          r_dp;
    logic          w_dp;
    logic [2:0]    r_an;
    logic [2:0]    w_an;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h40;
            4'd1:    f_decode = 7'h79;
            4'd2:    f_decode = 7'h24;
            4'd3:    f_decode = 7'h30;
            4'd4:    f_decode = 7'h19;
            4'd5:    f_decode = 7'h12;
            4'd6:    f_decode = 7'h02;
            4'd7:    f_decode = 7'h78;
            4'd8:    f_decode = 7'h00;
            4'd9:    f_decode = 7'h10;
            default: f_decode = 7'h3F;
        endcase
    endfunction

    assign w_tc = (r_cnt == CW'(REFRESH_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIG0;
            r_cnt   <= '0;
            r_s1    <= 4'd0;
            r_s0    <= 4'd0;
            r_ms0   <= 4'd0;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_an    <= 3'b111;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_tc ? '0 : r_cnt + 1'b1;
            // All three digits move together so a carry never tears the display.
            if (!bus.hold) begin
                r_s1  <= bus.s1;
                r_s0  <= bus.s0;
                r_ms0 <= bus.ms0;
            end
            r_seg   <= w_seg;
            r_dp    <= w_dp;
            r_an    <= w_an;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_digit     = r_ms0;
        w_an        = 3'b111;
        w_dp        = 1'b1;
        w_seg       = 7'h7F;
        w_show      = (r_cnt >= CW'(BLANK_CYCLES)) && !bus.blank;
        case (r_state)
            DIG0: begin
                w_digit = r_ms0;
                if (w_show) w_an = 3'b110;
                if (w_tc) w_state_nxt = DIG1;
            end
            DIG1: begin
                w_digit = r_s0;
                if (w_show) begin
                    w_an = 3'b101;
                    w_dp = 1'b0;
                end
                if (w_tc) w_state_nxt = DIG2;
            end
            DIG2: begin
                w_digit = r_s1;
                if (w_show && !((LZB != 0) && (r_s1 == 4'd0))) w_an = 3'b011;
                if (w_tc) w_state_nxt = DIG0;
            end
            default: w_state_nxt = DIG0;
        endcase
        if (w_an != 3'b111) w_seg = f_decode(w_digit);
    end

    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
    assign bus.an  = r_an;
endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// Randomised and directed checks of bcd_seg7_scanner (LZB=1 and LZB=0 copies)
// against a time-index reference model of the scan schedule.
module tb_bcd_seg7_scanner;
    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] s1, s0, ms0;
    logic       hold, blank;

    int n_checks = 0;
    int n_pass   = 0;

    bcd_seg7_scanner_if bus_a ();
    bcd_seg7_scanner_if bus_b ();

    assign bus_a.s1 = s1;  assign bus_a.s0 = s0;  assign bus_a.ms0 = ms0;
    assign bus_a.hold = hold;  assign bus_a.blank = blank;
    assign bus_b.s1 = s1;  assign bus_b.s0 = s0;  assign bus_b.ms0 = ms0;
    assign bus_b.hold = hold;  assign bus_b.blank = blank;

    bcd_seg7_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZB(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    bcd_seg7_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZB(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // t = cycles elapsed since reset release when the output is computed
    function automatic logic [2:0] f_an(int t, logic [11:0] snap, logic blk, bit lzb);
        int slot, c;
        slot = (t / RD) % 3;
        c    = t % RD;
        if (blk || c < BC) return 3'b111;
        if (slot == 2 && lzb && snap[11:8] == 4'd0) return 3'b111;
        return ~(3'b001 << slot);
    endfunction

    function automatic logic [6:0] f_seg(int t, logic [11:0] snap, logic blk, bit lzb);
        int slot;
        logic [3:0] d;
        slot = (t / RD) % 3;
        d = 4'((snap >> (4 * slot)) & 12'hF);
        if (f_an(t, snap, blk, lzb) == 3'b111) return 7'h7F;
        return seg_tbl[d];
    endfunction

    int         m_t;
    logic [11:0] m_snap;
    logic [6:0] ea_seg, eb_seg;
    logic       ea_dp, eb_dp;
    logic [2:0] ea_an, eb_an;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0;  m_snap <= 12'h000;
            ea_seg <= 7'h7F;  ea_dp <= 1'b1;  ea_an <= 3'b111;
            eb_seg <= 7'h7F;  eb_dp <= 1'b1;  eb_an <= 3'b111;
        end else begin
            ea_an  <= f_an(m_t, m_snap, blank, 1'b1);
            ea_seg <= f_seg(m_t, m_snap, blank, 1'b1);
            ea_dp  <= (f_an(m_t, m_snap, blank, 1'b1) == 3'b101) ? 1'b0 : 1'b1;
            eb_an  <= f_an(m_t, m_snap, blank, 1'b0);
            eb_seg <= f_seg(m_t, m_snap, blank, 1'b0);
            eb_dp  <= (f_an(m_t, m_snap, blank, 1'b0) == 3'b101) ? 1'b0 : 1'b1;
            m_t    <= m_t + 1;
            if (!hold) m_snap <= {s1, s0, ms0};
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [2:0] x_an;
        logic [6:0] x_seg;
        rst_n = 1'b0;  s1 = 4'd0;  s0 = 4'd0;  ms0 = 4'd5;  hold = 1'b0;  blank = 1'b0;
        #12;
        n_checks++;
        if ({bus_a.seg, bus_a.dp, bus_a.an} !== {7'h7F, 1'b1, 3'b111})
            $display("FAIL reset_out seg=%h dp=%b an=%b required 7f/1/111", bus_a.seg, bus_a.dp, bus_a.an);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            x_an  = (k >= 3 && k <= 8) ? 3'b110 : 3'b111;
            x_seg = (k >= 3 && k <= 8) ? 7'h12 : 7'h7F;
            n_checks++;
            if ({bus_a.an, bus_a.seg, bus_a.dp} !== {x_an, x_seg, 1'b1} ||
                {bus_b.an, bus_b.seg, bus_b.dp} !== {ea_an, ea_seg, ea_dp})
                $display("FAIL first_digit edge=%0d an=%b seg=%h required an=%b seg=%h", k, bus_a.an, bus_a.seg, x_an, x_seg);
            else n_pass++;
        end
    endtask

    task automatic test_scan();
        int c_d0 = 0, c_d1 = 0, c_d2 = 0, c_bl = 0;
        s1 = 4'd1;  s0 = 4'd2;  ms0 = 4'd3;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an} !==
                {ea_seg, ea_dp, ea_an, eb_seg, eb_dp, eb_an})
                $display("FAIL scan_model t=%0d a=%h/%b/%b required %h/%b/%b", m_t, bus_a.seg, bus_a.dp, bus_a.an, ea_seg, ea_dp, ea_an);
            else n_pass++;
            if (k >= 2) begin
                if (bus_a.an == 3'b110 && bus_a.seg == 7'h30 && bus_a.dp) c_d0++;
                if (bus_a.an == 3'b101 && bus_a.seg == 7'h24 && !bus_a.dp) c_d1++;
                if (bus_a.an == 3'b011 && bus_a.seg == 7'h79 && bus_a.dp) c_d2++;
                if (bus_a.an == 3'b111 && bus_a.seg == 7'h7F && bus_a.dp) c_bl++;
            end
        end
        n_checks++;
        if ({c_d0, c_d1, c_d2, c_bl} !== {32'd12, 32'd12, 32'd12, 32'd12})
            $display("FAIL scan_counts d0=%0d d1=%0d d2=%0d blank=%0d required 12 each", c_d0, c_d1, c_d2, c_bl);
        else n_pass++;
    endtask

    task automatic test_leading_zero();
        int a_d2 = 0, a_dark = 0, b_d2 = 0;
        s1 = 4'd0;  s0 = 4'd7;  ms0 = 4'($urandom_range(0, 9));
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an} !==
                {ea_seg, ea_dp, ea_an, eb_seg, eb_dp, eb_an})
                $display("FAIL lzb_model t=%0d a_an=%b b_an=%b b_seg=%h required %b %b %h", m_t, bus_a.an, bus_b.an, bus_b.seg, ea_an, eb_an, eb_seg);
            else n_pass++;
            if (k >= 2) begin
                if (bus_a.an == 3'b011) a_d2++;
                if (bus_a.an == 3'b111 && bus_a.seg == 7'h7F) a_dark++;
                if (bus_b.an == 3'b011 && bus_b.seg == 7'h40) b_d2++;
            end
        end
        n_checks++;
        if (a_d2 != 0 || a_dark != 24 || b_d2 != 12)
            $display("FAIL lzb_counts a_d2=%0d a_dark=%0d b_d2=%0d required 0 24 12", a_d2, a_dark, b_d2);
        else n_pass++;
    endtask

    task automatic test_hold();
        int nines = 0, good = 0;
        bit found = 0;
        s1 = 4'd1;  s0 = 4'd2;  ms0 = 4'd3;
        repeat (3) @(negedge clk);
        hold = 1'b1;  s1 = 4'd9;  s0 = 4'd9;  ms0 = 4'd9;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an} !==
                {ea_seg, ea_dp, ea_an, eb_seg, eb_dp, eb_an})
                $display("FAIL hold_model t=%0d seg=%h an=%b required %h %b", m_t, bus_a.seg, bus_a.an, ea_seg, ea_an);
            else n_pass++;
            if (bus_a.an != 3'b111 && bus_a.seg == 7'h10) nines++;
            if (bus_a.an == 3'b110 && bus_a.seg == 7'h30) good++;
        end
        n_checks++;
        if (nines != 0 || good != 12)
            $display("FAIL hold_frozen nines=%0d ms0_3=%0d required 0 12", nines, good);
        else n_pass++;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus_a.an != 3'b111) found = 1;
        end
        n_checks++;
        if (!found || bus_a.seg !== 7'h10)
            $display("FAIL hold_release found=%0d seg=%h required 1 10", found, bus_a.seg);
        else n_pass++;
    endtask

    task automatic test_invalid_blank();
        int dash = 0;
        s1 = 4'd1;  s0 = 4'd2;  ms0 = 4'hC;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_a.seg, bus_a.dp, bus_a.an} !== {ea_seg, ea_dp, ea_an})
                $display("FAIL invalid_model t=%0d seg=%h an=%b required %h %b", m_t, bus_a.seg, bus_a.an, ea_seg, ea_an);
            else n_pass++;
            if (k >= 2 && bus_a.an == 3'b110 && bus_a.seg == 7'h3F) dash++;
        end
        n_checks++;
        if (dash != 6) $display("FAIL invalid_dash count=%0d required 6", dash);
        else n_pass++;
        blank = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an} !==
                {7'h7F, 1'b1, 3'b111, 7'h7F, 1'b1, 3'b111})
                $display("FAIL blank_dark k=%0d seg=%h dp=%b an=%b required 7f 1 111", k, bus_a.seg, bus_a.dp, bus_a.an);
            else n_pass++;
        end
        blank = 1'b0;
        for (int k = 0; k < 24; k++) begin
            s1 = 4'($urandom_range(0, 15));
            @(negedge clk);
            n_checks++;
            if ({bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an} !==
                {ea_seg, ea_dp, ea_an, eb_seg, eb_dp, eb_an})
                $display("FAIL blank_timing t=%0d an=%b seg=%h required %b %h", m_t, bus_a.an, bus_a.seg, ea_an, ea_seg);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            if ((k % 5) == 0) begin
                s1  = 4'($urandom_range(0, 15));
                s0  = 4'($urandom_range(0, 15));
                ms0 = 4'($urandom_range(0, 15));
                hold  = ($urandom_range(0, 3) == 0);
                blank = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            n_checks++;
            if ({bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an} !==
                {ea_seg, ea_dp, ea_an, eb_seg, eb_dp, eb_an})
                $display("FAIL random_model t=%0d a=%h/%b/%b b=%h/%b/%b required %h/%b/%b %h/%b/%b",
                         m_t, bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an,
                         ea_seg, ea_dp, ea_an, eb_seg, eb_dp, eb_an);
            else n_pass++;
        end
        hold = 1'b0;  blank = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        logic [2:0] x_an;
        s1 = 4'd1;  s0 = 4'd2;  ms0 = 4'd3;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus_a.an == 3'b101) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL reset_mid_wait an=%b required 101 within 40 cycles", bus_a.an);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.seg, bus_a.dp, bus_a.an, bus_b.seg, bus_b.dp, bus_b.an} !==
            {7'h7F, 1'b1, 3'b111, 7'h7F, 1'b1, 3'b111})
            $display("FAIL reset_mid_instant seg=%h dp=%b an=%b required 7f 1 111", bus_a.seg, bus_a.dp, bus_a.an);
        else n_pass++;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            x_an = (k >= 3) ? 3'b110 : 3'b111;
            n_checks++;
            if (bus_a.an !== x_an || {bus_a.seg, bus_a.dp} !== {ea_seg, ea_dp})
                $display("FAIL reset_mid_restart edge=%0d an=%b seg=%h required an=%b seg=%h", k, bus_a.an, bus_a.seg, x_an, ea_seg);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_leading_zero();
        test_hold();
        test_invalid_blank();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
